// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer:
// FSM states, opcode fields and the strobe bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4,
    S_HALTED = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  localparam logic [1:0] OP_ALU_R  = 2'b00;
  localparam logic [1:0] OP_ALU_I  = 2'b01;
  localparam int         OP_BR_BIT = 1;

  typedef struct packed {
    logic imem_req;
    logic ir_write;
    logic pc_write;
    logic pc_src;
    logic reg_write;
    logic alu_src;
    logic imm_sel;
  } strobes_t;

endpackage

// File: rtl/fetch_timer.sv
// Counts FETCH cycles spent waiting for imem_ack;
// expire_o flags the last cycle allowed before timeout.
module fetch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle sequencer: fetch handshake, decode,
// exec/branch, writeback, halt and retire count.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       opcode,
  input  logic             imem_ack,
  input  logic             halt,
  output logic             imem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             ImmSel,
  output logic [2:0]       state_o,
  output logic             fetch_timeout,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] ret_q;
  logic             in_fetch;
  logic             retire;
  logic             tmr_exp;
  strobes_t         stb;

  assign in_fetch = (state_q == S_FETCH);
  assign retire   = (state_q == S_WB) ||
                    (state_q == S_BRANCH);

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (in_fetch & imem_ack),
    .inc_i    (in_fetch & ~imem_ack),
    .expire_o (tmr_exp)
  );

  // An ack on the final allowed cycle wins over expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack)
          state_d = S_DECODE;
        else if (tmr_exp)
          state_d = S_ERROR;
      end
      S_DECODE:
        state_d = opcode[OP_BR_BIT] ? S_BRANCH
                                    : S_EXEC;
      S_EXEC:
        state_d = S_WB;
      S_WB, S_BRANCH:
        state_d = halt ? S_HALTED : S_FETCH;
      S_HALTED:
        if (!halt)
          state_d = S_FETCH;
      S_ERROR:
        state_d = S_ERROR;
      default:
        state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        op_q <= opcode;
      if (retire)
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  // Strobes decode the registered state; reset masks them all.
  always_comb begin
    stb = '0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          stb.imem_req = 1'b1;
          stb.ir_write = imem_ack;
        end
        S_EXEC: begin
          stb.alu_src = (op_q == OP_ALU_I);
        end
        S_WB: begin
          stb.reg_write = 1'b1;
          stb.alu_src   = (op_q == OP_ALU_I);
          stb.pc_write  = 1'b1;
        end
        S_BRANCH: begin
          stb.pc_write = 1'b1;
          stb.pc_src   = 1'b1;
          stb.imm_sel  = 1'b1;
        end
        default: stb = '0;
      endcase
    end
  end

  assign imem_req      = stb.imem_req;
  assign IRWrite       = stb.ir_write;
  assign PCWrite       = stb.pc_write;
  assign PCSrc         = stb.pc_src;
  assign RegWrite      = stb.reg_write;
  assign ALUSrc        = stb.alu_src;
  assign ImmSel        = stb.imm_sel;
  assign state_o       = state_q;
  assign fetch_timeout = !reset &&
                         (state_q == S_ERROR);
  assign retired       = ret_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: vector table, directed
// corner sequences and randomized run against a model.
module tb_multi_cycle_ctrl;

  localparam int TO = 15;
  localparam int F  = 0;
  localparam int D  = 1;
  localparam int E  = 2;
  localparam int W  = 3;
  localparam int B  = 4;
  localparam int H  = 5;
  localparam int ER = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] opcode = 2'b00;
  logic       imem_ack = 1'b0;
  logic       halt = 1'b0;

  logic        imem_req, IRWrite, PCWrite, PCSrc;
  logic        RegWrite, ALUSrc, ImmSel;
  logic [2:0]  state_o;
  logic        fetch_timeout;
  logic [15:0] retired;

  logic        w_req, w_irw, w_pcw, w_pcs;
  logic        w_rw, w_als, w_imm;
  logic [2:0]  w_state;
  logic        w_tmo;
  logic [1:0]  w_ret;

  multi_cycle_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (16)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .imem_ack      (imem_ack),
    .halt          (halt),
    .imem_req      (imem_req),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .PCSrc         (PCSrc),
    .RegWrite      (RegWrite),
    .ALUSrc        (ALUSrc),
    .ImmSel        (ImmSel),
    .state_o       (state_o),
    .fetch_timeout (fetch_timeout),
    .retired       (retired)
  );

  multi_cycle_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (2)
  ) u_w2 (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .imem_ack      (imem_ack),
    .halt          (halt),
    .imem_req      (w_req),
    .IRWrite       (w_irw),
    .PCWrite       (w_pcw),
    .PCSrc         (w_pcs),
    .RegWrite      (w_rw),
    .ALUSrc        (w_als),
    .ImmSel        (w_imm),
    .state_o       (w_state),
    .fetch_timeout (w_tmo),
    .retired       (w_ret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: spec-level phase, latched op, waits, count.
  int          ms = F;
  logic [1:0]  mop = 2'b00;
  int          mwait = 0;
  int unsigned mret = 0;

  typedef struct {
    logic       r;
    logic [1:0] op;
    logic       a;
    logic       h;
    logic [2:0] st;
    logic [7:0] sb;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_strobes();
    logic [7:0] s;
    s = '0;
    if (!reset) begin
      case (ms)
        F: begin
          s[7] = 1'b1;
          s[6] = imem_ack;
        end
        E: s[2] = (mop == 2'b01);
        W: begin
          s[5] = 1'b1;
          s[3] = 1'b1;
          s[2] = (mop == 2'b01);
        end
        B: begin
          s[5] = 1'b1;
          s[4] = 1'b1;
          s[1] = 1'b1;
        end
        ER: s[0] = 1'b1;
        default: s = '0;
      endcase
    end
    return s;
  endfunction

  function automatic logic [7:0] dut_strobes();
    return {imem_req, IRWrite, PCWrite, PCSrc,
            RegWrite, ALUSrc, ImmSel, fetch_timeout};
  endfunction

  function automatic logic [7:0] w2_strobes();
    return {w_req, w_irw, w_pcw, w_pcs,
            w_rw, w_als, w_imm, w_tmo};
  endfunction

  task automatic model_step();
    if (reset) begin
      ms    = F;
      mop   = 2'b00;
      mwait = 0;
      mret  = 0;
    end else begin
      case (ms)
        F: begin
          if (imem_ack) begin
            ms    = D;
            mwait = 0;
          end else if (mwait == TO - 1) begin
            ms = ER;
          end else begin
            mwait++;
          end
        end
        D: begin
          mop = opcode;
          ms  = opcode[1] ? B : E;
        end
        E: ms = W;
        W, B: begin
          mret++;
          ms = halt ? H : F;
        end
        H: if (!halt) ms = F;
        default: ms = ER;
      endcase
    end
  endtask

  task automatic drive_check(input logic r,
                             input logic [1:0] op,
                             input logic a,
                             input logic h);
    logic [31:0] r16;
    logic [31:0] r2;
    reset    = r;
    opcode   = op;
    imem_ack = a;
    halt     = h;
    #2;
    r16 = mret & 32'hFFFF;
    r2  = mret & 32'h3;
    check("state", 32'(state_o), ms);
    check("strobes", 32'(dut_strobes()),
          32'(exp_strobes()));
    check("retired", 32'(retired), r16);
    check("state_w2", 32'(w_state), ms);
    check("strobes_w2", 32'(w2_strobes()),
          32'(exp_strobes()));
    check("retired_w2", 32'(w_ret), r2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic r,
                     input logic [1:0] op,
                     input logic a,
                     input logic h);
    drive_check(r, op, a, h);
    tick();
  endtask

  task automatic alu_instr(input logic [1:0] op);
    cyc(1'b0, op, 1'b1, 1'b0);
    cyc(1'b0, op, 1'b0, 1'b0);
    cyc(1'b0, op, 1'b0, 1'b0);
    cyc(1'b0, op, 1'b0, 1'b0);
  endtask

  initial begin
    int drought;
    logic r, a, h;
    logic [1:0] op;

    // {req,irw,pcw,pcsrc,rw,alusrc,imm,tmo}
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 3'd0,
                8'b0000_0000, 16'd0};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 1'b0, 3'd0,
                8'b1100_0000, 16'd0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 1'b0, 3'd1,
                8'b0000_0000, 16'd0};
    tbl[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 3'd2,
                8'b0000_0000, 16'd0};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 3'd3,
                8'b0010_1000, 16'd0};
    tbl[5]  = '{1'b0, 2'b00, 1'b1, 1'b0, 3'd0,
                8'b1100_0000, 16'd1};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 1'b0, 3'd1,
                8'b0000_0000, 16'd1};
    tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b0, 3'd4,
                8'b0011_0010, 16'd1};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 1'b0, 3'd0,
                8'b1000_0000, 16'd2};
    tbl[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 3'd0,
                8'b1100_0000, 16'd2};
    tbl[10] = '{1'b0, 2'b11, 1'b0, 1'b0, 3'd1,
                8'b0000_0000, 16'd2};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 3'd4,
                8'b0011_0010, 16'd2};
    tbl[12] = '{1'b1, 2'b00, 1'b1, 1'b0, 3'd0,
                8'b0000_0000, 16'd3};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive_check(tbl[i].r, tbl[i].op,
                  tbl[i].a, tbl[i].h);
      check("tbl_state", 32'(state_o),
            32'(tbl[i].st));
      check("tbl_strobes", 32'(dut_strobes()),
            32'(tbl[i].sb));
      check("tbl_retired", 32'(retired),
            32'(tbl[i].ret));
      tick();
    end

    // ALU reg-imm with three wait cycles
    repeat (3) cyc(1'b0, 2'b01, 1'b0, 1'b0);
    drive_check(1'b0, 2'b01, 1'b1, 1'b0);
    check("t2_irwrite_c4", 32'(IRWrite), 32'd1);
    tick();
    cyc(1'b0, 2'b01, 1'b0, 1'b0);
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t2_alusrc_exec", 32'(ALUSrc), 32'd1);
    tick();
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t2_alusrc_wb", 32'(ALUSrc), 32'd1);
    check("t2_regwrite_c7", 32'(RegWrite), 32'd1);
    tick();
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t2_retired", 32'(retired), 32'd1);
    tick();

    // Timeout: 15 ack-less FETCH cycles reach ERROR
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    repeat (TO - 1) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t4_fetch_last", 32'(state_o), 32'd0);
    tick();
    repeat (3) cyc(1'b0, 2'b00, 1'b1, 1'b0);
    drive_check(1'b0, 2'b00, 1'b1, 1'b0);
    check("t4_error_state", 32'(state_o), 32'd6);
    check("t4_sticky", 32'(fetch_timeout), 32'd1);
    check("t4_no_req", 32'(imem_req), 32'd0);
    tick();
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t4_cleared", 32'(fetch_timeout), 32'd0);
    tick();

    // Ack on the last allowed cycle wins
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    repeat (TO - 1) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t4_last_ack", 32'(state_o), 32'd1);
    tick();
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);

    // Halt raised in EXEC
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    drive_check(1'b0, 2'b00, 1'b0, 1'b1);
    check("t5_wb_done", 32'(RegWrite), 32'd1);
    tick();
    drive_check(1'b0, 2'b00, 1'b0, 1'b1);
    check("t5_halted", 32'(state_o), 32'd5);
    check("t5_quiet", 32'(dut_strobes()), 32'd0);
    tick();
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t5_still_halted", 32'(state_o), 32'd5);
    tick();
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t5_refetch", 32'(state_o), 32'd0);
    tick();

    // Reset during WB aborts, then 2-bit wrap
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    drive_check(1'b1, 2'b00, 1'b0, 1'b0);
    check("t6_no_regwrite", 32'(RegWrite), 32'd0);
    check("t6_no_pcwrite", 32'(PCWrite), 32'd0);
    tick();
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t6_state", 32'(state_o), 32'd0);
    check("t6_retired", 32'(retired), 32'd0);
    tick();
    repeat (5) alu_instr(2'b00);
    drive_check(1'b0, 2'b00, 1'b0, 1'b0);
    check("t6_wrap_w2", 32'(w_ret), 32'd1);
    check("t6_count16", 32'(retired), 32'd5);
    tick();

    // Randomized run against the model
    drought = 0;
    for (int n = 0; n < 4000; n++) begin
      if (drought == 0 &&
          $urandom_range(0, 299) == 0)
        drought = 20;
      r  = ($urandom_range(0, 199) == 0);
      op = 2'($urandom_range(0, 3));
      h  = ($urandom_range(0, 4) == 0);
      if (drought > 0) begin
        a = 1'b0;
        drought--;
      end else begin
        a = ($urandom_range(0, 9) < 6);
      end
      if (ms == ER && $urandom_range(0, 29) == 0)
        r = 1'b1;
      cyc(r, op, a, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
